uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmitter between two message requesters. Each requester hands over a 4-byte message; the block grants the transmitter round-robin, then drives the transmitter's write/enable/data/baud inputs byte by byte, pacing on Tx_BUSY. It sits between the 7-segment/command producers and the UART transmitter, and is the only driver of the transmitter's control inputs.

## Interface
- BUSY_TIMEOUT, 16: cycles to wait for Tx_BUSY to rise after a Tx_WR pulse before aborting.
- BAUD_RESET, 3'b111: baud_select value after reset.
- Clk  in  1  system clock (50 MHz); all logic on the rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- req0, req1  in  1  level request; one message per grant.
- msg0, msg1  in  32  message; byte [31:24] is sent first, [7:0] last; sampled only at grant.
- baud_cfg  in  3  baud setting; sampled only at grant.
- ack0, ack1  out  1  one-cycle pulse: message latched, requester may change msgN.
- done0, done1  out  1  one-cycle pulse: last byte finished (Tx_BUSY fell).
- err  out  1  one-cycle pulse: BUSY_TIMEOUT expired, message aborted.
- busy  out  1  high in every state except IDLE.
- Tx_BUSY  in  1  transmitter busy.
- Tx_WR, Tx_EN  out  1  transmitter write strobe / enable.
- Tx_DATA  out  8  transmitter data.
- baud_select  out  3  transmitter baud select.

## Operation
- All outputs registered. Reset values: Tx_WR=0, Tx_EN=0, Tx_DATA=0, baud_select=BAUD_RESET, ack*/done*/err=0, busy=0, byte counter=0, round-robin pointer = "last grant was 1" (req0 wins first tie).
- States: IDLE, LOAD, WRITE, WAIT_BUSY, WAIT_DONE.
- IDLE: if any req, pick owner: the sole requester, or on a tie the one not granted last. Latch msg and baud_cfg, update pointer, pulse ackN, set Tx_EN=1, Tx_DATA=msg[31:24], byte counter=0 -> LOAD.
- LOAD: Tx_DATA stable. If Tx_BUSY=0 -> WRITE; else stay (covers a transmitter still draining).
- WRITE: Tx_WR=1 for exactly this one cycle -> WAIT_BUSY, timeout counter cleared.
- WAIT_BUSY: Tx_WR=0. Tx_BUSY=1 -> WAIT_DONE. Counter reaches BUSY_TIMEOUT with Tx_BUSY=0 -> pulse err, Tx_EN=0 -> IDLE (no doneN).
- WAIT_DONE: on Tx_BUSY=0: counter=3 -> pulse doneN, Tx_EN=0 -> IDLE; else counter+1 (2-bit, no wrap used), Tx_DATA = next byte -> LOAD.
- Tx_DATA and baud_select held constant from LOAD through WAIT_DONE of each byte.
- A requester holding req high after ack/done issues a new request; round-robin then serves the other side first if it is requesting.
- reset mid-message: everything returns to reset values on that edge; message dropped, no doneN, no err.

## Timing
- req seen in IDLE at edge k: ack, Tx_EN, Tx_DATA=byte 3 valid from k+1; Tx_WR high during cycle k+2 (if Tx_BUSY=0).
- Byte-to-byte gap: Tx_BUSY low seen at edge m -> next Tx_WR high at cycle m+2.
- doneN asserts in the first IDLE cycle; a pending request is granted at that same edge, so the next ack appears one cycle after done.
- Timeout: err asserts BUSY_TIMEOUT+1 cycles after the Tx_WR cycle.
- req dropping after ack has no effect on the message in flight.

## Test plan
- Single req0, msg0=32'h8A313233, baud_cfg=3'b111, behavioural transmitter (busy 20 cycles) -> Tx_WR pulses carrying 8A,31,32,33 in order, each one cycle, Tx_EN high throughout, one ack0, one done0, baud_select=111.
- req0 and req1 raised in the same cycle after reset, msg1=32'h01020304 -> message 0 sent fully first, then message 1; next simultaneous pair -> req1 served first.
- req0 held high continuously with req1 pulsing -> grants alternate 0,1,0,1; no byte interleaving between messages.
- Transmitter never raises Tx_BUSY -> err pulse 17 cycles after Tx_WR, Tx_EN=0, busy=0, no done0; next request served normally.
- reset asserted during byte 2 -> next cycle all outputs at reset values, no done/err; subsequent req1 starts cleanly from byte [31:24].
- baud_cfg changed 3'b111->3'b000 mid-message -> baud_select stays 111 until the next grant, then 000.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter between two 4-byte requesters
module uart_tx_arbiter #(
    parameter int         BUSY_TIMEOUT = 16,
    parameter logic [2:0] BAUD_RESET   = 3'b111
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] msg0,
    input  logic [31:0] msg1,
    input  logic [2:0]  baud_cfg,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic        busy,
    input  logic        Tx_BUSY,
    output logic        Tx_WR,
    output logic        Tx_EN,
    output logic [7:0]  Tx_DATA,
    output logic [2:0]  baud_select
);

    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    state_t        state_q;
    logic          owner_q;
    logic          last_q;
    logic [23:0]   rest_q;
    logic [1:0]    byte_q;
    logic [TW-1:0] tmo_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          done0_q;
    logic          done1_q;
    logic          err_q;
    logic          busy_q;
    logic          wr_q;
    logic          en_q;
    logic [7:0]    data_q;
    logic [2:0]    baud_q;

    logic          grant_d;
    logic [31:0]   msg_d;

    // On a tie the side not granted last wins; a sole requester always wins.
    always_comb begin
        grant_d = req1;
        if (req0 && req1) begin
            grant_d = ~last_q;
        end
        msg_d = grant_d ? msg1 : msg0;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            rest_q  <= '0;
            byte_q  <= '0;
            tmo_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            wr_q    <= 1'b0;
            en_q    <= 1'b0;
            data_q  <= '0;
            baud_q  <= BAUD_RESET;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req0 || req1) begin
                        owner_q <= grant_d;
                        last_q  <= grant_d;
                        ack0_q  <= ~grant_d;
                        ack1_q  <= grant_d;
                        en_q    <= 1'b1;
                        data_q  <= msg_d[31:24];
                        rest_q  <= msg_d[23:0];
                        baud_q  <= baud_cfg;
                        byte_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Waiting here also absorbs a transmitter still draining a prior byte.
                    if (!Tx_BUSY) begin
                        wr_q    <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    tmo_q   <= '0;
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (Tx_BUSY) begin
                        state_q <= S_WAIT_DONE;
                    end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
                        err_q   <= 1'b1;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!Tx_BUSY) begin
                        if (byte_q == 2'd3) begin
                            done0_q <= ~owner_q;
                            done1_q <= owner_q;
                            en_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            byte_q  <= byte_q + 1'b1;
                            data_q  <= rest_q[23:16];
                            rest_q  <= {rest_q[15:0], 8'h00};
                            state_q <= S_LOAD;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign Tx_WR       = wr_q;
    assign Tx_EN       = en_q;
    assign Tx_DATA     = data_q;
    assign baud_select = baud_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam logic [2:0] K_ACK0  = 3'd1;
    localparam logic [2:0] K_ACK1  = 3'd2;
    localparam logic [2:0] K_WR    = 3'd3;
    localparam logic [2:0] K_DONE0 = 3'd4;
    localparam logic [2:0] K_DONE1 = 3'd5;
    localparam logic [2:0] K_ERR   = 3'd6;

    typedef struct packed {
        logic [2:0] kind;
        logic [7:0] data;
        logic [2:0] baud;
        logic       en;
        logic       bsy;
    } ev_t;

    typedef struct {
        int          c0;
        int          c1;
        logic [31:0] m0;
        logic [31:0] m1;
        logic [2:0]  b;
        logic [2:0]  b_alt;
        logic        mute;
        int          first;
    } vec_t;

    logic        Clk;
    logic        reset;
    logic        req0, req1;
    logic [31:0] msg0, msg1;
    logic [2:0]  baud_cfg;
    logic        ack0, ack1, done0, done1, err, busy;
    logic        Tx_BUSY;
    logic        Tx_WR, Tx_EN;
    logic [7:0]  Tx_DATA;
    logic [2:0]  baud_select;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    logic ref_last    = 1'b1;
    logic tx_mute     = 1'b0;
    int   tx_len      = 20;
    int   tx_lat      = 0;

    uart_tx_arbiter #(.BUSY_TIMEOUT(16), .BAUD_RESET(3'b111)) dut (
        .Clk(Clk), .reset(reset),
        .req0(req0), .req1(req1), .msg0(msg0), .msg1(msg1), .baud_cfg(baud_cfg),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1), .err(err), .busy(busy),
        .Tx_BUSY(Tx_BUSY), .Tx_WR(Tx_WR), .Tx_EN(Tx_EN), .Tx_DATA(Tx_DATA),
        .baud_select(baud_select)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Behavioural transmitter: busy rises tx_lat cycles after a write and stays up tx_len cycles.
    initial begin
        Tx_BUSY = 1'b0;
        forever begin
            @(negedge Clk);
            if (Tx_WR && !tx_mute) begin
                repeat (tx_lat) @(negedge Clk);
                Tx_BUSY = 1'b1;
                repeat (tx_len) @(negedge Clk);
                Tx_BUSY = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input logic [2:0] k, input logic [7:0] d, input logic [2:0] b,
                               input logic e, input logic s);
        mk = {k, d, b, e, s};
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_Tx_WR"}, Tx_WR, 0);
        check({tag, "_Tx_EN"}, Tx_EN, 0);
        check({tag, "_Tx_DATA"}, Tx_DATA, 0);
        check({tag, "_baud_select"}, baud_select, 3'b111);
        check({tag, "_ack0"}, ack0, 0);
        check({tag, "_ack1"}, ack1, 0);
        check({tag, "_done0"}, done0, 0);
        check({tag, "_done1"}, done1, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Requester N keeps its req high until it has been acked cN times.
    task automatic run_case(input int c0, input int c1, input logic [31:0] m0, input logic [31:0] m1,
                            input logic [2:0] b, input logic [2:0] b_alt, input logic mute,
                            input int first);
        ev_t         exp_q[$];
        int          exp_dt[$];
        ev_t         act_q[$];
        int          act_t[$];
        int          rem0, rem1, got0, got1, terms, n_terms, extra, t, idx;
        logic        o;
        logic [31:0] m;
        logic [2:0]  bb;
        logic        acked;
        rem0 = c0; rem1 = c1; got0 = 0; got1 = 0; terms = 0; n_terms = 0;
        extra = 0; t = 0; idx = 0; acked = 1'b0;

        while (rem0 + rem1 > 0) begin
            o = (rem0 > 0 && rem1 > 0) ? ~ref_last : (rem1 > 0);
            ref_last = o;
            if (o) rem1--; else rem0--;
            m  = o ? m1 : m0;
            bb = (idx == 0) ? b : b_alt;
            exp_q.push_back(mk(o ? K_ACK1 : K_ACK0, m[31:24], bb, 1'b1, 1'b1));
            exp_dt.push_back(idx == 0 ? -1 : 1);
            if (mute) begin
                exp_q.push_back(mk(K_WR, m[31:24], bb, 1'b1, 1'b1));
                exp_dt.push_back(1);
                exp_q.push_back(mk(K_ERR, 8'h00, bb, 1'b0, 1'b0));
                exp_dt.push_back(17);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    exp_q.push_back(mk(K_WR, 8'(m >> (24 - 8 * k)), bb, 1'b1, 1'b1));
                    exp_dt.push_back(k == 0 ? 1 : -1);
                end
                exp_q.push_back(mk(o ? K_DONE1 : K_DONE0, 8'h00, bb, 1'b0, 1'b0));
                exp_dt.push_back(-1);
            end
            n_terms++;
            idx++;
        end

        tx_mute = mute;
        @(negedge Clk);
        msg0 = m0; msg1 = m1; baud_cfg = b;
        req0 = (c0 > 0);
        req1 = (c1 > 0);
        while (t < 1200 && extra < 4) begin
            @(negedge Clk);
            t++;
            if (ack0) begin
                act_q.push_back(mk(K_ACK0, Tx_DATA, baud_select, Tx_EN, busy)); act_t.push_back(cyc);
                got0++; acked = 1'b1;
                if (got0 >= c0) req0 = 1'b0;
            end
            if (ack1) begin
                act_q.push_back(mk(K_ACK1, Tx_DATA, baud_select, Tx_EN, busy)); act_t.push_back(cyc);
                got1++; acked = 1'b1;
                if (got1 >= c1) req1 = 1'b0;
            end
            if (acked) baud_cfg = b_alt;
            if (Tx_WR) begin
                act_q.push_back(mk(K_WR, Tx_DATA, baud_select, Tx_EN, busy)); act_t.push_back(cyc);
            end
            if (done0) begin
                act_q.push_back(mk(K_DONE0, 8'h00, baud_select, Tx_EN, busy)); act_t.push_back(cyc); terms++;
            end
            if (done1) begin
                act_q.push_back(mk(K_DONE1, 8'h00, baud_select, Tx_EN, busy)); act_t.push_back(cyc); terms++;
            end
            if (err) begin
                act_q.push_back(mk(K_ERR, 8'h00, baud_select, Tx_EN, busy)); act_t.push_back(cyc); terms++;
            end
            if (terms >= n_terms) extra++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (extra < 4) begin
            vectors++;
            miscompares++;
            $display("FAIL case_timeout: got %0d finished messages, expected %0d", terms, n_terms);
        end

        check("event_count", act_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < act_q.size()) begin
                check($sformatf("event%0d", i), act_q[i], exp_q[i]);
                if (i > 0 && exp_dt[i] >= 0)
                    check($sformatf("event%0d_delay", i), act_t[i] - act_t[i-1], exp_dt[i]);
            end
        end
        if (first >= 0 && act_q.size() > 0)
            check("first_owner", act_q[0].kind, (first != 0) ? K_ACK1 : K_ACK0);
    endtask

    initial begin
        vec_t tbl[7];
        int   nwr, nev, t;
        int   rc0, rc1;
        logic rmute;

        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        msg0 = '0; msg1 = '0; baud_cfg = 3'b000;
        repeat (3) @(negedge Clk);
        check_reset_vals("reset");
        reset = 1'b0;

        tbl[0] = '{1, 1, 32'h8A313233, 32'h01020304, 3'b111, 3'b000, 1'b0, 0};
        tbl[1] = '{1, 0, 32'hDEADBEEF, 32'h00000000, 3'b010, 3'b101, 1'b0, 0};
        tbl[2] = '{1, 1, 32'h11223344, 32'h55667788, 3'b011, 3'b110, 1'b0, 1};
        tbl[3] = '{0, 1, 32'h00000000, 32'hCAFEF00D, 3'b110, 3'b001, 1'b1, 1};
        tbl[4] = '{1, 0, 32'h0F1E2D3C, 32'h00000000, 3'b000, 3'b111, 1'b0, 0};
        tbl[5] = '{2, 2, 32'h13579BDF, 32'h2468ACE0, 3'b101, 3'b010, 1'b0, 1};
        tbl[6] = '{3, 1, 32'hF0E1D2C3, 32'hB4A59687, 3'b100, 3'b011, 1'b0, 1};

        foreach (tbl[i]) begin
            tx_len = 20;
            tx_lat = i % 3;
            run_case(tbl[i].c0, tbl[i].c1, tbl[i].m0, tbl[i].m1, tbl[i].b, tbl[i].b_alt,
                     tbl[i].mute, tbl[i].first);
        end

        // Reset while the second byte is in flight.
        tx_mute = 1'b0; tx_len = 20; tx_lat = 0;
        @(negedge Clk);
        req0 = 1'b1; msg0 = 32'hAABBCCDD; baud_cfg = 3'b010;
        nwr = 0; t = 0;
        while (nwr < 2 && t < 300) begin
            @(negedge Clk);
            t++;
            if (ack0) req0 = 1'b0;
            if (Tx_WR) nwr++;
        end
        check("midmsg_bytes_before_reset", nwr, 2);
        repeat (3) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        check_reset_vals("midmsg");
        reset = 1'b0;
        nev = 0;
        repeat (30) begin
            @(negedge Clk);
            if (ack0 || ack1 || done0 || done1 || err || Tx_WR) nev++;
        end
        check("post_reset_quiet", nev, 0);
        ref_last = 1'b1;
        run_case(0, 1, 32'h00000000, 32'h5A6B7C8D, 3'b001, 3'b100, 1'b0, 1);

        for (int r = 0; r < 24; r++) begin
            rc0 = $urandom_range(0, 2);
            rc1 = $urandom_range(0, 2);
            if (rc0 + rc1 == 0) rc0 = 1;
            rmute = ($urandom_range(0, 5) == 0);
            tx_len = $urandom_range(1, 20);
            tx_lat = $urandom_range(0, 4);
            run_case(rc0, rc1, $urandom, $urandom, 3'($urandom), 3'($urandom), rmute, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
